// File: rtl/des_seq_pkg.sv
// Shared types for the DES block sequencer: FSM state encoding, per-state output flags
// and default widths.
package des_seq_pkg;

    localparam int BLOCK_W_DEF = 64;
    localparam int KEY_W_DEF   = 64;
    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 1023;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        RUN   = 3'd2,
        ACK   = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic busy;
        logic in_ready;
        logic core_enable;
        logic core_ack;
        logic out_valid;
        logic job_done;
    } flags_t;

    // Output flags are registered together with the state they belong to.
    function automatic flags_t state_flags(input state_t s);
        flags_t f;
        f             = '0;
        f.busy        = (s != IDLE);
        f.in_ready    = (s == FETCH);
        f.core_enable = (s == RUN);
        f.core_ack    = (s == ACK);
        f.out_valid   = (s == OUT);
        f.job_done    = (s == DONE);
        return f;
    endfunction

endpackage

// File: rtl/des_seq_watchdog.sv
// Watchdog for the RUN state: counts RUN cycles from a clear and flags expiry
// on the TIMEOUT-th cycle.
module des_seq_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_cnt;

    // Counter value k-1 during the k-th RUN cycle, so expiry lands on cycle TIMEOUT.
    assign o_expired = i_run && (r_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/des_block_sequencer.sv
// Sequences ciphertext blocks through one DES decrypt core (enable/done/ack handshake).
// Define DES_CBC_EN for CBC chaining of the plaintext; the default build is ECB.
module des_block_sequencer
    import des_seq_pkg::*;
#(
    parameter int BLOCK_W = BLOCK_W_DEF,
    parameter int KEY_W   = KEY_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [KEY_W-1:0]   cfg_key,
    input  logic [BLOCK_W-1:0] cfg_iv,
    input  logic [CNT_W-1:0]   num_blocks,
    output logic               busy,
    output logic               job_done,
    output logic               error,
    output logic [CNT_W-1:0]   blocks_done,
    input  logic               in_valid,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [BLOCK_W-1:0] out_data,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] core_message,
    output logic [KEY_W-1:0]   core_key,
    output logic               core_enable,
    output logic               core_ack,
    input  logic               core_done,
    input  logic [BLOCK_W-1:0] core_result
);

    state_t             r_state;
    flags_t             r_flags;
    logic [KEY_W-1:0]   r_key;
    logic [CNT_W-1:0]   r_num;
    logic [CNT_W-1:0]   r_blocks_done;
    logic               r_error;
    logic [BLOCK_W-1:0] r_message;
    logic [BLOCK_W-1:0] r_out_data;

    logic               w_fetch_hs;
    logic               w_run;
    logic               w_expired;
    logic               w_job_start;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [BLOCK_W-1:0] w_plain;

    assign w_fetch_hs  = (r_state == FETCH) && in_valid;
    assign w_run       = (r_state == RUN);
    assign w_job_start = (r_state == IDLE) && start && (num_blocks != '0);
    assign w_count_nxt = r_blocks_done + 1'b1;

`ifdef DES_CBC_EN
    // r_mask keeps the previous ciphertext (or IV) for the block currently in the core.
    logic [BLOCK_W-1:0] r_chain;
    logic [BLOCK_W-1:0] r_mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_chain <= '0;
            r_mask  <= '0;
        end else if (w_job_start) begin
            r_chain <= cfg_iv;
        end else if (w_fetch_hs) begin
            r_mask  <= r_chain;
            r_chain <= in_data;
        end
    end

    assign w_plain = core_result ^ r_mask;
`else
    logic w_unused_iv;
    assign w_unused_iv = ^cfg_iv;
    assign w_plain     = core_result;
`endif

    des_seq_watchdog #(
        .TIMEOUT   (TIMEOUT)
    ) u_watchdog (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_clear   (w_fetch_hs),
        .i_run     (w_run),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_flags       <= '0;
            r_key         <= '0;
            r_num         <= '0;
            r_blocks_done <= '0;
            r_error       <= 1'b0;
            r_message     <= '0;
            r_out_data    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_job_start) begin
                        r_key         <= cfg_key;
                        r_num         <= num_blocks;
                        r_blocks_done <= '0;
                        r_error       <= 1'b0;
                        r_state       <= FETCH;
                        r_flags       <= state_flags(FETCH);
                    end else if (start) begin
                        r_state <= DONE;
                        r_flags <= state_flags(DONE);
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        r_message <= in_data;
                        r_state   <= RUN;
                        r_flags   <= state_flags(RUN);
                    end
                end
                RUN: begin
                    // A result arriving on the expiry cycle is still taken.
                    if (core_done) begin
                        r_out_data <= w_plain;
                        r_state    <= ACK;
                        r_flags    <= state_flags(ACK);
                    end else if (w_expired) begin
                        r_error <= 1'b1;
                        r_state <= DONE;
                        r_flags <= state_flags(DONE);
                    end
                end
                ACK: begin
                    if (!core_done) begin
                        r_state <= OUT;
                        r_flags <= state_flags(OUT);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_blocks_done <= w_count_nxt;
                        if (w_count_nxt == r_num) begin
                            r_state <= DONE;
                            r_flags <= state_flags(DONE);
                        end else begin
                            r_state <= FETCH;
                            r_flags <= state_flags(FETCH);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_flags <= state_flags(IDLE);
                end
                default: begin
                    r_state <= IDLE;
                    r_flags <= state_flags(IDLE);
                end
            endcase
        end
    end

    assign busy         = r_flags.busy;
    assign in_ready     = r_flags.in_ready;
    assign core_enable  = r_flags.core_enable;
    assign core_ack     = r_flags.core_ack;
    assign out_valid    = r_flags.out_valid;
    assign job_done     = r_flags.job_done;
    assign error        = r_error;
    assign blocks_done  = r_blocks_done;
    assign out_data     = r_out_data;
    assign core_message = r_message;
    assign core_key     = r_key;

endmodule

// File: tb/tb_des_block_sequencer.sv
// Bench for des_block_sequencer with a behavioural DES core model and a
// spec-level reference for ECB/CBC plaintext, counts and job pulses.
`timescale 1ns/1ps
module tb_des_block_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] cfg_key;
    logic [63:0] cfg_iv;
    logic [15:0] num_blocks;
    logic        busy;
    logic        job_done;
    logic        error;
    logic [15:0] blocks_done;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    logic [63:0] core_message;
    logic [63:0] core_key;
    logic        core_enable;
    logic        core_ack;
    logic        core_done;
    logic [63:0] core_result;

    int n_checks = 0;
    int n_fail   = 0;

    des_block_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_key      (cfg_key),
        .cfg_iv       (cfg_iv),
        .num_blocks   (num_blocks),
        .busy         (busy),
        .job_done     (job_done),
        .error        (error),
        .blocks_done  (blocks_done),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .core_message (core_message),
        .core_key     (core_key),
        .core_enable  (core_enable),
        .core_ack     (core_ack),
        .core_done    (core_done),
        .core_result  (core_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core decrypt function: the reference vector, else a keyed non-trivial mix.
    function automatic logic [63:0] des_ref(input logic [63:0] msg, input logic [63:0] key);
        if (key == 64'h1334_5779_9BBC_DFF1 && msg == 64'h85E8_1354_0F0A_B405)
            return 64'h0123_4567_89AB_CDEF;
        return {msg[31:0], msg[63:32]} ^ key ^ 64'h5A5A_0F0F_3C3C_9696;
    endfunction

    // Core model: done rises m_lat cycles into enable, falls once ack is seen.
    int m_lat   = 4;
    bit m_never = 1'b0;
    int m_cnt   = 0;
    initial begin
        core_done   = 1'b0;
        core_result = '0;
    end
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            core_done = 1'b0;
            m_cnt     = 0;
        end else if (core_ack) begin
            core_done = 1'b0;
            m_cnt     = 0;
        end else if (core_enable && !core_done && !m_never) begin
            m_cnt = m_cnt + 1;
            if (m_cnt >= m_lat) begin
                core_done   = 1'b1;
                core_result = des_ref(core_message, core_key);
                m_cnt       = 0;
            end
        end else if (!core_enable) begin
            m_cnt = 0;
        end
    end

    // Free-running event counters; tests take differences.
    int jd_cnt  = 0;
    int en_cyc  = 0;
    int rdy_cyc = 0;
    always @(negedge clk) begin
        if (job_done)    jd_cnt  = jd_cnt + 1;
        if (core_enable) en_cyc  = en_cyc + 1;
        if (in_ready)    rdy_cyc = rdy_cyc + 1;
    end

    logic [63:0] ct  [8];
    logic [63:0] got [8];
    int          got_n;
    logic [63:0] g_key;
    logic [63:0] g_iv;

    function automatic logic [63:0] exp_out(input int b);
`ifdef DES_CBC_EN
        return des_ref(ct[b], g_key) ^ ((b == 0) ? g_iv : ct[b-1]);
`else
        return des_ref(ct[b], g_key);
`endif
    endfunction

    task automatic start_job(input int nb);
        @(negedge clk);
        cfg_key    = g_key;
        cfg_iv     = g_iv;
        num_blocks = 16'(nb);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        cfg_key    = ~g_key;
        cfg_iv     = ~g_iv;
        num_blocks = 16'hFFFF;
    endtask

    task automatic run_job(input int nb, input int stall_blk, input int stall_cyc, input bit rnd);
        int          guard;
        logic [63:0] held;
        got_n = 0;
        start_job(nb);
        for (int b = 0; b < nb; b++) begin
            if (rnd) repeat ($urandom_range(0, 3)) @(negedge clk);
            in_valid = 1'b1;
            in_data  = ct[b];
            guard    = 0;
            while (!in_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) begin
                n_checks++; n_fail++;
                $display("FAIL fetch_wait blk %0d: in_ready=%b required 1", b, in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom};
            n_checks++;
            if (core_message !== ct[b] || core_key !== g_key || core_enable !== 1'b1) begin
                n_fail++;
                $display("FAIL core_drive blk %0d: msg=%h key=%h en=%b required msg=%h key=%h en=1",
                         b, core_message, core_key, core_enable, ct[b], g_key);
            end
            guard = 0;
            while (!out_valid && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            if (!out_valid) begin
                n_checks++; n_fail++;
                $display("FAIL out_wait blk %0d: out_valid=%b required 1", b, out_valid);
                return;
            end
            held = out_data;
            if (b == stall_blk) begin
                repeat (stall_cyc) begin
                    @(negedge clk);
                    n_checks++;
                    if (out_data !== held || out_valid !== 1'b1) begin
                        n_fail++;
                        $display("FAIL stall_hold blk %0d: data=%h valid=%b required %h valid=1",
                                 b, out_data, out_valid, held);
                    end
                end
            end else if (rnd) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            got[got_n] = held;
            got_n      = got_n + 1;
            n_checks++;
            if (blocks_done !== 16'(b + 1)) begin
                n_fail++;
                $display("FAIL blocks_done blk %0d: got %0d required %0d", b, blocks_done, b + 1);
            end
        end
    endtask

    task automatic check_job(input string name, input int nb, input int jd0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (got_n !== nb) begin
            n_fail++;
            $display("FAIL %s count: got %0d outputs required %0d", name, got_n, nb);
        end
        for (int b = 0; b < got_n; b++) begin
            n_checks++;
            if (got[b] !== exp_out(b)) begin
                n_fail++;
                $display("FAIL %s data blk %0d: got %h required %h", name, b, got[b], exp_out(b));
            end
        end
        n_checks++;
        if (jd_cnt - jd0 !== 1 || busy !== 1'b0 || blocks_done !== 16'(nb)) begin
            n_fail++;
            $display("FAIL %s end: pulses=%0d busy=%b done=%0d required 1/0/%0d",
                     name, jd_cnt - jd0, busy, blocks_done, nb);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, job_done, error, in_ready, out_valid, core_enable, core_ack} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: flags=%b required 0000000",
                     {busy, job_done, error, in_ready, out_valid, core_enable, core_ack});
        end
        n_checks++;
        if (blocks_done !== '0 || out_data !== '0 || core_message !== '0 || core_key !== '0) begin
            n_fail++;
            $display("FAIL reset_data: bd=%0d out=%h msg=%h key=%h required all 0",
                     blocks_done, out_data, core_message, core_key);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b in_ready=%b required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_known_vector;
        int jd0 = jd_cnt;
        m_lat = 4;
        g_key = 64'h1334_5779_9BBC_DFF1;
        g_iv  = '0;
        ct[0] = 64'h85E8_1354_0F0A_B405;
        run_job(1, -1, 0, 1'b0);
        check_job("known", 1, jd0);
        n_checks++;
        if (got[0] !== 64'h0123_4567_89AB_CDEF) begin
            n_fail++;
            $display("FAIL known_plain: got %h required 0123456789abcdef", got[0]);
        end
    endtask

    task automatic test_multi_stall;
        int jd0 = jd_cnt;
        m_lat = 16;
        g_key = {$urandom, $urandom};
        g_iv  = {$urandom, $urandom};
        for (int b = 0; b < 3; b++) ct[b] = {$urandom, $urandom};
        run_job(3, 1, 5, 1'b0);
        check_job("stall3", 3, jd0);
    endtask

    task automatic test_timeout;
        int guard;
        int en0 = en_cyc;
        int jd0 = jd_cnt;
        m_never = 1'b1;
        ct[0] = {$urandom, $urandom};
        start_job(2);
        in_valid = 1'b1;
        in_data  = ct[0];
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        guard    = 0;
        while (!job_done && guard < 1100) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (job_done !== 1'b1 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_abort: job_done=%b error=%b required 1 1", job_done, error);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || error !== 1'b1 || blocks_done !== '0) begin
            n_fail++;
            $display("FAIL timeout_after: busy=%b error=%b bd=%0d required 0 1 0", busy, error, blocks_done);
        end
        n_checks++;
        if (en_cyc - en0 !== 1023 || jd_cnt - jd0 !== 1) begin
            n_fail++;
            $display("FAIL timeout_len: enable cycles=%0d pulses=%0d required 1023 1",
                     en_cyc - en0, jd_cnt - jd0);
        end
        m_never = 1'b0;
    endtask

    task automatic test_zero_blocks;
        int guard;
        int jd0  = jd_cnt;
        int en0  = en_cyc;
        int rdy0 = rdy_cyc;
        @(negedge clk);
        num_blocks = '0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!job_done && guard < 3) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (job_done !== 1'b1 || guard !== 0) begin
            n_fail++;
            $display("FAIL zero_done: job_done=%b after %0d extra cycles required 1 after 0", job_done, guard);
        end
        @(negedge clk);
        n_checks++;
        if (job_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_idle: job_done=%b busy=%b required 0 0", job_done, busy);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (rdy_cyc - rdy0 !== 0 || en_cyc - en0 !== 0 || jd_cnt - jd0 !== 1) begin
            n_fail++;
            $display("FAIL zero_side: ready=%0d enable=%0d pulses=%0d required 0 0 1",
                     rdy_cyc - rdy0, en_cyc - en0, jd_cnt - jd0);
        end
        n_checks++;
        if (error !== 1'b1 || blocks_done !== '0) begin
            n_fail++;
            $display("FAIL zero_keep: error=%b bd=%0d required 1 0", error, blocks_done);
        end
    endtask

    task automatic test_error_clear;
        int jd0 = jd_cnt;
        m_lat = 2;
        g_key = {$urandom, $urandom};
        g_iv  = {$urandom, $urandom};
        ct[0] = {$urandom, $urandom};
        run_job(1, -1, 0, 1'b1);
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL error_clear: error=%b required 0", error);
        end
        check_job("errclr", 1, jd0);
    endtask

    task automatic test_reset_mid_run;
        int guard;
        int jd0;
        m_lat = 30;
        g_key = {$urandom, $urandom};
        g_iv  = {$urandom, $urandom};
        ct[0] = {$urandom, $urandom};
        start_job(2);
        in_valid = 1'b1;
        in_data  = ct[0];
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (core_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: core_enable=%b required 1", core_enable);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, job_done, error, in_ready, out_valid, core_enable, core_ack} !== 7'b0) begin
            n_fail++;
            $display("FAIL mid_ctrl: flags=%b required 0000000",
                     {busy, job_done, error, in_ready, out_valid, core_enable, core_ack});
        end
        n_checks++;
        if (blocks_done !== '0 || out_data !== '0 || core_message !== '0 || core_key !== '0) begin
            n_fail++;
            $display("FAIL mid_data: bd=%0d out=%h msg=%h key=%h required all 0",
                     blocks_done, out_data, core_message, core_key);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        m_lat = 3;
        jd0   = jd_cnt;
        for (int b = 0; b < 2; b++) ct[b] = {$urandom, $urandom};
        run_job(2, -1, 0, 1'b0);
        check_job("post_reset", 2, jd0);
    endtask

`ifdef DES_CBC_EN
    task automatic test_cbc;
        int jd0 = jd_cnt;
        m_lat = 5;
        g_key = {$urandom, $urandom};
        g_iv  = '0;
        ct[0] = {$urandom, $urandom};
        ct[1] = {$urandom, $urandom};
        run_job(2, -1, 0, 1'b0);
        n_checks++;
        if (got[0] !== des_ref(ct[0], g_key) || got[1] !== (des_ref(ct[1], g_key) ^ ct[0])) begin
            n_fail++;
            $display("FAIL cbc_chain: got %h %h required %h %h", got[0], got[1],
                     des_ref(ct[0], g_key), des_ref(ct[1], g_key) ^ ct[0]);
        end
        check_job("cbc", 2, jd0);
    endtask
`endif

    task automatic test_random;
        int nb;
        int jd0;
        for (int j = 0; j < 6; j++) begin
            nb    = $urandom_range(1, 5);
            m_lat = $urandom_range(1, 8);
            g_key = {$urandom, $urandom};
            g_iv  = {$urandom, $urandom};
            for (int b = 0; b < nb; b++) ct[b] = {$urandom, $urandom};
            jd0 = jd_cnt;
            run_job(nb, $urandom_range(0, nb - 1), $urandom_range(0, 3), 1'b1);
            check_job("random", nb, jd0);
        end
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        cfg_key    = '0;
        cfg_iv     = '0;
        num_blocks = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        g_key      = '0;
        g_iv       = '0;
        got_n      = 0;
        test_reset();
        test_known_vector();
        test_multi_stall();
        test_timeout();
        test_zero_blocks();
        test_error_clear();
        test_reset_mid_run();
`ifdef DES_CBC_EN
        test_cbc();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
